// File: rtl/dht11_sensor_model.sv
// Behavioural DHT11 humidity/temperature sensor on an open-drain line: accepts a host
// start request and answers with the standard response and a 40-bit data frame.
module dht11_sensor_model #(
  parameter int unsigned CLK_MHZ      = 50,
  parameter int unsigned START_MIN_US = 18000,
  parameter int unsigned WAIT_US      = 30
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] I_HUM_INT,
  input  logic [7:0] I_HUM_DEC,
  input  logic [7:0] I_TMP_INT,
  input  logic [7:0] I_TMP_DEC,
  input  logic       I_BAD_CRC,
  inout  wire        IO_DHT11,
  output logic       O_BUSY,
  output logic       O_DONE,
  output logic       O_DRV_LOW
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START_LOW = 3'd1;
  localparam logic [2:0] S_WAIT      = 3'd2;
  localparam logic [2:0] S_RESP_LOW  = 3'd3;
  localparam logic [2:0] S_RESP_HIGH = 3'd4;
  localparam logic [2:0] S_BIT_LOW   = 3'd5;
  localparam logic [2:0] S_BIT_HIGH  = 3'd6;
  localparam logic [2:0] S_END_LOW   = 3'd7;

  localparam int unsigned PRESC_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_MHZ - 1);
  localparam logic [15:0] START_MIN = 16'(START_MIN_US);
  localparam logic [15:0] WAIT_LEN  = 16'(WAIT_US);

  logic [2:0]         state;
  logic [2:0]         state_next;
  logic               sync_1;
  logic               sync_2;
  logic               sync_3;
  logic               rise;
  logic               fall;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [15:0]        us_cnt;
  logic [15:0]        phase_len;
  logic               phase_end;
  logic [39:0]        shift_reg;
  logic [5:0]         bit_cnt;
  logic               load_frame;
  logic               shift_bit;
  logic [7:0]         crc_sum;
  logic [7:0]         crc;

  assign rise = sync_2 & ~sync_3;
  assign fall = ~sync_2 & sync_3;
  assign tick = (presc == PRESC_MAX);

  assign crc_sum = I_HUM_INT + I_HUM_DEC + I_TMP_INT + I_TMP_DEC;
  assign crc     = I_BAD_CRC ? ~crc_sum : crc_sum;

  always_comb begin
    phase_len = 16'd0;
    case (state)
      S_WAIT:      phase_len = WAIT_LEN;
      S_RESP_LOW:  phase_len = 16'd80;
      S_RESP_HIGH: phase_len = 16'd80;
      S_BIT_LOW:   phase_len = 16'd50;
      S_BIT_HIGH:  phase_len = shift_reg[39] ? 16'd70 : 16'd28;
      S_END_LOW:   phase_len = 16'd50;
      default:     phase_len = 16'd0;
    endcase
  end

  assign phase_end = tick && (us_cnt == phase_len - 16'd1);

  always_comb begin
    state_next = state;
    load_frame = 1'b0;
    shift_bit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) state_next = S_START_LOW;
      end
      S_START_LOW: begin
        if (rise) begin
          if (us_cnt >= START_MIN) begin
            state_next = S_WAIT;
            load_frame = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_WAIT:      if (phase_end) state_next = S_RESP_LOW;
      S_RESP_LOW:  if (phase_end) state_next = S_RESP_HIGH;
      S_RESP_HIGH: if (phase_end) state_next = S_BIT_LOW;
      S_BIT_LOW:   if (phase_end) state_next = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (phase_end) begin
          shift_bit  = 1'b1;
          state_next = (bit_cnt == 6'd39) ? S_END_LOW : S_BIT_LOW;
        end
      end
      S_END_LOW:   if (phase_end) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Decoded straight from the state register so an async reset frees the line at once.
  assign O_DRV_LOW = (state == S_RESP_LOW) || (state == S_BIT_LOW) || (state == S_END_LOW);
  assign O_BUSY    = (state != S_IDLE) && (state != S_START_LOW);
  assign IO_DHT11  = O_DRV_LOW ? 1'b0 : 1'bz;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // Synchronizer clears to 0 so a host low already in progress yields no falling edge.
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_3    <= 1'b0;
      state     <= S_IDLE;
      O_DONE    <= 1'b0;
      presc     <= '0;
      us_cnt    <= 16'd0;
      shift_reg <= 40'd0;
      bit_cnt   <= 6'd0;
    end else begin
      sync_1 <= IO_DHT11;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
      state  <= state_next;
      O_DONE <= (state == S_END_LOW) && (state_next == S_IDLE);

      // Restarting the timebase on every phase change keeps each phase exact.
      if (state_next != state) begin
        presc  <= '0;
        us_cnt <= 16'd0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick && (us_cnt != 16'hffff)) us_cnt <= us_cnt + 16'd1;
      end

      if (load_frame) begin
        shift_reg <= {I_HUM_INT, I_HUM_DEC, I_TMP_INT, I_TMP_DEC, crc};
        bit_cnt   <= 6'd0;
      end else if (shift_bit) begin
        shift_reg <= {shift_reg[38:0], 1'b0};
        bit_cnt   <= bit_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_dht11_sensor_model.sv
// Bench for dht11_sensor_model: acts as the host, times every line phase and decodes
// the frame, comparing against a byte-level model of the DHT11 protocol.
module tb_dht11_sensor_model;

  localparam int C    = 2;
  localparam int SMIN = 400;
  localparam int WUS  = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hum_int = 8'd0;
  logic [7:0] hum_dec = 8'd0;
  logic [7:0] tmp_int = 8'd0;
  logic [7:0] tmp_dec = 8'd0;
  logic       bad_crc = 1'b0;
  logic       host_low = 1'b0;
  logic       busy;
  logic       done;
  logic       drv;
  wire        dq;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int line_err = 0;
  int busy_err = 0;

  pullup (dq);
  assign dq = host_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  dht11_sensor_model #(
    .CLK_MHZ(C),
    .START_MIN_US(SMIN),
    .WAIT_US(WUS)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .I_HUM_INT(hum_int),
    .I_HUM_DEC(hum_dec),
    .I_TMP_INT(tmp_int),
    .I_TMP_DEC(tmp_dec),
    .I_BAD_CRC(bad_crc),
    .IO_DHT11(dq),
    .O_BUSY(busy),
    .O_DONE(done),
    .O_DRV_LOW(drv)
  );

  // Line must be 0 whenever the sensor drives, and pulled high when nobody does.
  always begin
    @(negedge clk);
    #2;
    if (drv && dq !== 1'b0) line_err++;
    if (!drv && !host_low && dq !== 1'b1) line_err++;
    if (done) done_cnt++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [39:0] model_frame(input logic [31:0] d, input bit bad);
    logic [7:0] s;
    s = d[31:24] + d[23:16] + d[15:8] + d[7:0];
    if (bad) s = ~s;
    return {d, s};
  endfunction

  function automatic bit bad_len(input int cyc, input int us);
    return (cyc < us * C - C) || (cyc > us * C + 3);
  endfunction

  task automatic tick_us(input int n);
    repeat (n * C) @(negedge clk);
  endtask

  task automatic host_start(input int us);
    @(negedge clk);
    host_low = 1'b1;
    tick_us(us);
    host_low = 1'b0;
  endtask

  // Count cycles while O_DRV_LOW holds 'level'; optionally pulse the host low 1 us.
  task automatic measure(input logic level, input int glitch_at, input bit chk_busy,
                         output int cyc, output bit tmo);
    cyc = 1;
    tmo = 1'b0;
    forever begin
      @(negedge clk);
      if (glitch_at >= 0) begin
        if (cyc == glitch_at) host_low = 1'b1;
        if (cyc == glitch_at + C) host_low = 1'b0;
      end
      if (drv !== level) break;
      if (chk_busy && busy !== 1'b1) busy_err++;
      cyc++;
      if (cyc > 200 * C) begin
        tmo = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [31:0] data, input bit bad, input bit glitch,
                           input int change_bit, input int stop_bit,
                           output logic [39:0] got, output int terr);
    int cyc;
    bit tmo;
    bit b;
    {hum_int, hum_dec, tmp_int, tmp_dec} = data;
    bad_crc = bad;
    got = '0;
    terr = 0;
    host_start(SMIN + 100);
    measure(1'b0, -1, 1'b0, cyc, tmo);
    if (tmo || bad_len(cyc, WUS)) terr++;
    if (tmo) return;
    measure(1'b1, -1, 1'b1, cyc, tmo);
    if (tmo || bad_len(cyc, 80)) terr++;
    if (tmo) return;
    measure(1'b0, glitch ? 40 * C : -1, 1'b1, cyc, tmo);
    if (tmo || bad_len(cyc, 80)) terr++;
    if (tmo) return;
    for (int i = 0; i < 40; i++) begin
      if (i == change_bit) {hum_int, hum_dec, tmp_int, tmp_dec} = {4{8'h12}};
      if (i == stop_bit) return;
      measure(1'b1, -1, 1'b1, cyc, tmo);
      if (tmo || bad_len(cyc, 50)) terr++;
      if (tmo) return;
      measure(1'b0, -1, 1'b1, cyc, tmo);
      b = (cyc > 49 * C);
      got[39-i] = b;
      if (tmo || bad_len(cyc, b ? 70 : 28)) terr++;
      if (tmo) return;
    end
    measure(1'b1, -1, 1'b1, cyc, tmo);
    if (tmo || bad_len(cyc, 50)) terr++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (drv !== 1'b0) begin errors++; $display("FAIL reset_drv got %b exp 0", drv); end
    checks++; if (dq !== 1'b1) begin errors++; $display("FAIL reset_line got %b exp 1", dq); end
    rst = 1'b0;
    tick_us(5);
  endtask

  task automatic test_basic_frame;
    logic [39:0] got;
    logic [39:0] exp;
    int terr;
    int d0;
    int be;
    exp = model_frame(32'h5500aa00, 1'b0);
    d0 = done_cnt;
    be = busy_err;
    run_frame(32'h5500aa00, 1'b0, 1'b0, -1, -1, got, terr);
    checks++; if (got !== 40'h5500aa00ff) begin errors++; $display("FAIL basic_frame got %010h exp 5500aa00ff", got); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got[39-8*k -: 8] !== exp[39-8*k -: 8]) begin
        errors++; $display("FAIL basic_byte%0d got %02h exp %02h", k, got[39-8*k -: 8], exp[39-8*k -: 8]);
      end
    end
    checks++; if (terr !== 0) begin errors++; $display("FAIL basic_timing got %0d bad phases exp 0", terr); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done got %0d exp 1", done_cnt - d0); end
    checks++; if (busy_err !== be) begin errors++; $display("FAIL basic_busy got %0d lows exp 0", busy_err - be); end
  endtask

  task automatic test_short_start;
    int bad;
    int d0;
    int lens[2];
    lens[0] = SMIN / 4;
    lens[1] = int'($urandom_range(SMIN / 8, SMIN - 10));
    for (int t = 0; t < 2; t++) begin
      d0 = done_cnt;
      bad = 0;
      host_start(lens[t]);
      repeat (100 * C) begin
        @(negedge clk);
        if (drv !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL short_start%0d got %0d active cycles exp 0", t, bad); end
      checks++; if (done_cnt !== d0) begin errors++; $display("FAIL short_done%0d got %0d exp 0", t, done_cnt - d0); end
    end
  endtask

  task automatic test_crc_all_ones;
    logic [39:0] got;
    logic [39:0] exp;
    logic [7:0]  want;
    int terr;
    for (int bad = 0; bad < 2; bad++) begin
      exp = model_frame(32'hffffffff, bad[0]);
      want = bad[0] ? 8'h03 : 8'hfc;
      run_frame(32'hffffffff, bad[0], 1'b0, -1, -1, got, terr);
      checks++; if (got[7:0] !== want) begin errors++; $display("FAIL crc%0d got %02h exp %02h", bad, got[7:0], want); end
      checks++; if (got !== exp) begin errors++; $display("FAIL crc_frame%0d got %010h exp %010h", bad, got, exp); end
      checks++; if (terr !== 0) begin errors++; $display("FAIL crc_timing%0d got %0d exp 0", bad, terr); end
    end
  endtask

  task automatic test_midframe_change;
    logic [39:0] got;
    logic [39:0] exp;
    logic [31:0] d;
    int terr;
    int d0;
    d = $urandom;
    exp = model_frame(d, 1'b0);
    d0 = done_cnt;
    run_frame(d, 1'b0, 1'b0, 10, -1, got, terr);
    checks++; if (got !== exp) begin errors++; $display("FAIL change_frame got %010h exp %010h", got, exp); end
    checks++; if (terr !== 0) begin errors++; $display("FAIL change_timing got %0d exp 0", terr); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL change_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_glitch;
    logic [39:0] got;
    logic [39:0] exp;
    logic [31:0] d;
    int terr;
    int d0;
    d = $urandom;
    exp = model_frame(d, 1'b0);
    d0 = done_cnt;
    run_frame(d, 1'b0, 1'b1, -1, -1, got, terr);
    checks++; if (got !== exp) begin errors++; $display("FAIL glitch_frame got %010h exp %010h", got, exp); end
    checks++; if (terr !== 0) begin errors++; $display("FAIL glitch_timing got %0d exp 0", terr); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL glitch_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [39:0] got;
    logic [39:0] exp;
    logic [31:0] d;
    int terr;
    int d0;
    int bad;
    d0 = done_cnt;
    run_frame($urandom, 1'b0, 1'b0, -1, 20, got, terr);
    repeat (5) @(negedge clk);
    checks++; if (drv !== 1'b1) begin errors++; $display("FAIL rst_pre_drv got %b exp 1", drv); end
    rst = 1'b1;
    #1;
    checks++; if (drv !== 1'b0) begin errors++; $display("FAIL rst_mid_drv got %b exp 0", drv); end
    checks++; if (dq !== 1'b1) begin errors++; $display("FAIL rst_mid_line got %b exp 1", dq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    repeat (3) @(negedge clk);
    // Host is already low when reset lifts; that low must not count as a start.
    host_low = 1'b1;
    rst = 1'b0;
    tick_us(SMIN + 100);
    host_low = 1'b0;
    bad = 0;
    repeat (100 * C) begin
      @(negedge clk);
      if (busy !== 1'b0 || drv !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_stale_start got %0d active cycles exp 0", bad); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rst_done got %0d exp 0", done_cnt - d0); end
    d = $urandom;
    exp = model_frame(d, 1'b0);
    run_frame(d, 1'b0, 1'b0, -1, -1, got, terr);
    checks++; if (got !== exp) begin errors++; $display("FAIL rst_recover_frame got %010h exp %010h", got, exp); end
    checks++; if (terr !== 0) begin errors++; $display("FAIL rst_recover_timing got %0d exp 0", terr); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rst_recover_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_line_integrity;
    checks++; if (line_err !== 0) begin errors++; $display("FAIL line_integrity got %0d bad samples exp 0", line_err); end
    checks++; if (busy_err !== 0) begin errors++; $display("FAIL busy_integrity got %0d bad samples exp 0", busy_err); end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_short_start;
    test_crc_all_ones;
    test_midframe_change;
    test_glitch;
    test_reset_mid_frame;
    test_line_integrity;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
